async_fifo: RTL and testbench
=============================

# async_fifo

Dual-clock first-in/first-out buffer that moves DATA_WIDTH-bit words from a write clock domain to an independent read clock domain. It uses Gray-coded pointers with two-stage synchronizers. It sits at clock-domain boundaries, for example between a 100 MHz producer and a roughly 71 MHz consumer. Words come out in write order with no loss or duplication. Full and empty flags are conservative, so they may lag but never lie.

## Interface
- Clocking: each domain has one clock; reset is asynchronous and active-low. Clocks are `wr_clk` and `rd_clk`; resets are `wr_rst_n` and `rd_rst_n`.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 4, address width; depth is 2^ADDR_WIDTH words (16 by default).

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst_n  in  1  write-domain asynchronous active-low reset.
- rd_clk  in  1  read-domain clock.
- rd_rst_n  in  1  read-domain asynchronous active-low reset.
- wr_data  in  DATA_WIDTH  word to write.
- wr_en  in  1  write request.
- full  out  1  FIFO full (wr_clk domain, registered).
- rd_data  out  DATA_WIDTH  head-of-FIFO word (first-word-fall-through).
- rd_en  in  1  read/pop request.
- empty  out  1  FIFO empty (rd_clk domain, registered).

## Operation
- Storage is a 2^ADDR_WIDTH x DATA_WIDTH dual-port memory.
  - Written on wr_clk.
  - Read asynchronously at the read address.
  - Not reset.
- Pointers:
  - wr_ptr and rd_ptr are (ADDR_WIDTH+1)-bit binary counters, each mirrored by a registered Gray code.
  - The low ADDR_WIDTH bits address the memory; the MSB is the wrap bit.
  - Counters wrap modulo 2^(ADDR_WIDTH+1).
- Write: when wr_en=1 and full=0 at a wr_clk rising edge:
  - mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  - wr_ptr increments.
  - When wr_en=1 and full=1, the write is ignored; pointer and memory are unchanged.
- Read: rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]] continuously.
  - rd_data is valid whenever empty=0, and the caller samples it in the same cycle it pops.
  - When rd_en=1 and empty=0 at an rd_clk rising edge, rd_ptr increments.
  - When rd_en=1 and empty=1, the read is ignored.
  - rd_data is don't-care while empty=1.
- Synchronization:
  - The write Gray pointer passes through 2 rd_clk flops into the read domain.
  - The read Gray pointer passes through 2 wr_clk flops into the write domain.
- Flag computation:
  - empty <= (next read Gray pointer == synchronized write Gray pointer).
  - full <= (next write Gray pointer == synchronized read Gray pointer with its top two bits inverted).
  - Both flags are registered from the next-pointer value.
- Simultaneous write and read in their respective domains are always legal. Each flag only ever errs conservatively: it stays asserted longer than strictly necessary.
- Reset:
  - wr_rst_n clears the write pointer, its Gray copy, the write-side synchronizers and full, giving full=0.
  - rd_rst_n clears the read pointer, its Gray copy, the read-side synchronizers and empty, giving empty=1.
  - Both resets must be asserted together. Resetting only one side mid-operation is unsupported and flushes nothing coherently.

## Timing
- full asserts on the same wr_clk edge that accepts the 2^ADDR_WIDTH-th unread word. No overwrite is possible.
- empty asserts on the same rd_clk edge that pops the last word.
- empty deasserts no later than the 3rd rd_clk rising edge after the wr_clk edge that wrote into an empty FIFO, and no earlier than the 2nd.
- full deasserts 2-3 wr_clk rising edges after the rd_clk edge that popped from a full FIFO.
- Throughput is one word per clock on each side when not flag-limited.
- After reset release, the first write is accepted on the next wr_clk edge.

## Test plan
- Reset: hold both resets low 20 ns -> full=0, empty=1. rd_en pulses while empty are ignored and no pointer moves.
- Single word: write 0x00A5 into an empty FIFO -> empty falls within 3 rd_clk edges with rd_data=0x00A5. Pop -> empty=1 on the same edge.
- Fill: write 0..15 with no reads -> full=1 on the 16th accepting edge. A 17th write of 0xFFFF is dropped. Reading back yields 0..15, then empty=1.
- Wrap-around: write and read 40 words in bursts of 10 -> pointers wrap twice and data stays in order with no mismatch.
- Streaming: wr_clk 10 ns, rd_clk 14 ns, writer writes 0..49 whenever full=0, reader pops whenever empty=0 -> all 50 words arrive as 0..49 in order. The writer observes full stalls; the run ends with empty=1 and full=0.
- Full-release latency: from full, one pop -> full clears after 2-3 wr_clk edges, and exactly one further write is then accepted before full reasserts.

Source files
------------

// File: rtl/async_fifo.sv
`timescale 1ns/1ps
// Dual-clock FIFO with Gray-coded pointers and 2-flop synchronizers; first-word-fall-through read port.
// Flags are registered from next-pointer values: they assert on the causing edge and release 2-3 far-side edges later.
module async_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Full when the pointers differ only in the wrap bit; in Gray code that inverts the top two bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic          wr_push;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_gray_s1_q, rd_gray_s2_q;
    logic          full_q, full_d;

    always_comb begin
        wr_push   = wr_en & ~full_q;
        wr_ptr_d  = wr_ptr_q + PW'(wr_push);
        wr_gray_d = bin2gray(wr_ptr_d);
        full_d    = (wr_gray_d == (rd_gray_s2_q ^ FULL_MASK));
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_ptr_q     <= '0;
            wr_gray_q    <= '0;
            rd_gray_s1_q <= '0;
            rd_gray_s2_q <= '0;
            full_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_gray_q    <= wr_gray_d;
            rd_gray_s1_q <= rd_gray_q;
            rd_gray_s2_q <= rd_gray_s1_q;
            full_q       <= full_d;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // ---------------- read domain ----------------
    logic          rd_pop;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] wr_gray_s1_q, wr_gray_s2_q;
    logic          empty_q, empty_d;

    always_comb begin
        rd_pop    = rd_en & ~empty_q;
        rd_ptr_d  = rd_ptr_q + PW'(rd_pop);
        rd_gray_d = bin2gray(rd_ptr_d);
        empty_d   = (rd_gray_d == wr_gray_s2_q);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_q     <= '0;
            rd_gray_q    <= '0;
            wr_gray_s1_q <= '0;
            wr_gray_s2_q <= '0;
            empty_q      <= 1'b1;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            rd_gray_q    <= rd_gray_d;
            wr_gray_s1_q <= wr_gray_q;
            wr_gray_s2_q <= wr_gray_s1_q;
            empty_q      <= empty_d;
        end
    end

    assign rd_data = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: tb/tb_async_fifo.sv
`timescale 1ns/1ps
// Directed bench for async_fifo with a queue scoreboard spanning both clock domains.
module tb_async_fifo;

    logic        wr_clk = 1'b0;
    logic        rd_clk = 1'b0;
    logic        wr_rst_n;
    logic        rd_rst_n;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        full;
    logic [15:0] rd_data;
    logic        rd_en;
    logic        empty;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb [$];

    always #5 wr_clk = ~wr_clk;
    always #7 rd_clk = ~rd_clk;

    async_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .wr_clk   (wr_clk),
        .wr_rst_n (wr_rst_n),
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .empty    (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one word for one wr_clk edge; acceptance follows the registered full flag.
    task automatic wr_word(input logic [15:0] d, output bit acc);
        wr_data = d;
        wr_en   = 1'b1;
        acc     = !full;
        @(posedge wr_clk); #1;
        wr_en   = 1'b0;
        if (acc) sb.push_back(d);
    endtask

    task automatic wr_until(input logic [15:0] d, inout int stalls);
        int n;
        bit acc;
        n = 0;
        while (full && n < 60) begin
            @(posedge wr_clk); #1;
            n++;
            stalls++;
        end
        if (full) check("wr_timeout", {31'd0, full}, 32'd0);
        else wr_word(d, acc);
    endtask

    task automatic rd_pop(input string tag);
        logic [15:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
        check(tag, {16'd0, rd_data}, {16'd0, exp});
        rd_en = 1'b1;
        @(posedge rd_clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_ne(input int max, output int edges);
        edges = 0;
        while (empty && edges < max) begin
            @(posedge rd_clk); #1;
            edges++;
        end
    endtask

    task automatic pop_n(input int n, input string tag);
        int e;
        for (int i = 0; i < n; i++) begin
            wait_ne(8, e);
            if (empty) begin
                check({tag, "_timeout"}, {31'd0, empty}, 32'd0);
                return;
            end
            rd_pop(tag);
        end
    endtask

    initial begin
        int  edges;
        int  stalls;
        int  got;
        int  cyc;
        bit  acc;

        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        stalls   = 0;

        // Reset
        #20;
        check("reset_full",  {31'd0, full},  32'd0);
        check("reset_empty", {31'd0, empty}, 32'd1);
        #3;
        wr_rst_n = 1'b1;
        rd_rst_n = 1'b1;
        rd_en = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        check("rd_while_empty", {31'd0, empty}, 32'd1);

        // Single word: a moved read pointer would expose an unwritten location here
        wr_word(16'h00A5, acc);
        check("single_acc", {31'd0, acc}, 32'd1);
        wait_ne(6, edges);
        check("single_empty_fall", {31'd0, empty}, 32'd0);
        check("single_lat_max", {31'd0, (edges <= 3)}, 32'd1);
        check("single_lat_min", {31'd0, (edges >= 2)}, 32'd1);
        rd_pop("single_data");
        check("single_empty_pop", {31'd0, empty}, 32'd1);

        // Fill to depth, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            wr_word(16'(i), acc);
            check("fill_acc", {31'd0, acc}, 32'd1);
            check("fill_full", {31'd0, full}, (i == 15) ? 32'd1 : 32'd0);
        end
        wr_word(16'hFFFF, acc);
        check("overflow_drop", {31'd0, acc}, 32'd0);
        check("overflow_full", {31'd0, full}, 32'd1);
        pop_n(16, "fill_data");
        check("fill_empty", {31'd0, empty}, 32'd1);
        check("fill_sb", sb.size(), 32'd0);

        // Wrap-around in bursts of ten
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) wr_until(16'(16'h1000 + b * 10 + i), stalls);
            pop_n(10, "wrap_data");
            check("wrap_empty", {31'd0, empty}, 32'd1);
        end
        check("wrap_sb", sb.size(), 32'd0);

        // Streaming: fast writer, slower reader
        stalls = 0;
        got    = 0;
        cyc    = 0;
        fork
            begin
                for (int i = 0; i < 50; i++) wr_until(16'(i), stalls);
            end
            begin
                while (got < 50 && cyc < 800) begin
                    if (!empty) begin
                        rd_pop("stream_data");
                        got++;
                    end else begin
                        @(posedge rd_clk); #1;
                    end
                    cyc++;
                end
            end
        join
        check("stream_count", got, 32'd50);
        check("stream_stalls", {31'd0, (stalls > 0)}, 32'd1);
        repeat (8) @(posedge wr_clk);
        #1;
        check("stream_end_empty", {31'd0, empty}, 32'd1);
        check("stream_end_full",  {31'd0, full},  32'd0);

        // Full-release latency
        for (int i = 0; i < 16; i++) wr_word(16'(16'h2000 + i), acc);
        check("frel_full", {31'd0, full}, 32'd1);
        wait_ne(6, edges);
        rd_pop("frel_data");
        edges = 0;
        while (full && edges < 6) begin
            @(posedge wr_clk); #1;
            edges++;
        end
        check("frel_cleared", {31'd0, full}, 32'd0);
        check("frel_lat_max", {31'd0, (edges <= 3)}, 32'd1);
        check("frel_lat_min", {31'd0, (edges >= 2)}, 32'd1);
        wr_word(16'h2100, acc);
        check("frel_one_acc", {31'd0, acc}, 32'd1);
        check("frel_refull", {31'd0, full}, 32'd1);
        wr_word(16'h2101, acc);
        check("frel_second_drop", {31'd0, acc}, 32'd0);
        pop_n(16, "frel_drain");
        check("frel_empty", {31'd0, empty}, 32'd1);
        check("frel_sb", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
